// File: rtl/counter_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_mon_pkg
// Description : Shared types and constants for the counter sequence monitor:
//               monitor state encoding, direction encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_mon_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;

endpackage
`default_nettype wire

// File: rtl/counter_seq_predict.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_predict
// Description : Combinational next-value predictor for an up/down counter.
//               Given the previously observed count/tc and the registered
//               enable/mode, produces the expected count, expected tc and
//               whether the step is a wrap.
// Ports       : prev_i     - previously observed count
//               prev_tc_i  - previously observed terminal count
//               step_i     - counter advanced on this edge
//               dir_i      - 0 up, 1 down
//               exp_o      - expected count
//               exp_tc_o   - expected terminal count
//               wrap_o     - this step wraps around the count range
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_predict
  import counter_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic             prev_tc_i,
  input  logic             step_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] exp_o,
  output logic             exp_tc_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    // A disabled counter holds both its value and its tc flag.
    exp_o    = prev_i;
    exp_tc_o = prev_tc_i;
    wrap_o   = 1'b0;
    if (step_i) begin
      if (dir_i == DIR_UP) begin
        exp_o  = prev_i + ONE;
        wrap_o = &prev_i;
      end else begin
        exp_o  = prev_i - ONE;
        wrap_o = ~|prev_i;
      end
      exp_tc_o = wrap_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_monitor
// Description : Sequence checker for an up/down counter. Locks onto the
//               observed count after SYNC_LEN consistent steps, then flags
//               count (seq_err_o) and terminal-count (tc_err_o) violations and
//               counts wraps seen while locked (saturating).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               step_i, dir_i - registered counter enable / mode
//               count_i, tc_i - observed counter value / terminal count
//               clr_err_i     - clear sticky error, FAULT -> UNSYNC
//               locked_o      - monitor is locked
//               seq_err_o     - one-cycle count-mismatch pulse
//               tc_err_o      - one-cycle tc-mismatch pulse
//               err_sticky_o  - any error since last clear
//               wrap_cnt_o    - saturating count of wraps while locked
// Config      : COUNTER_MON_HOLD_CHECK_EN - when defined, step_i=0 cycles are
//               also checked while locked (count and tc must hold).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_monitor
  import counter_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WRAP_W   = DEF_WRAP_W,
  parameter int SYNC_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  input  logic              dir_i,
  input  logic [WIDTH-1:0]  count_i,
  input  logic              tc_i,
  input  logic              clr_err_i,
  output logic              locked_o,
  output logic              seq_err_o,
  output logic              tc_err_o,
  output logic              err_sticky_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  localparam int CNT_W = $clog2(SYNC_LEN + 1);
  localparam logic [CNT_W-1:0] SYNC_LEN_C = CNT_W'(SYNC_LEN);

  mon_state_e        state_q;
  logic [WIDTH-1:0]  prev_q;
  logic              prev_tc_q;
  logic [CNT_W-1:0]  good_q;
  logic              locked_q;
  logic              seq_err_q;
  logic              tc_err_q;
  logic              err_sticky_q;
  logic [WRAP_W-1:0] wrap_q;

  logic [WIDTH-1:0]  exp_cnt;
  logic              exp_tc;
  logic              wrap;
  logic              cnt_match;
  logic              tc_match;
  logic              chk_en;
  logic [CNT_W-1:0]  good_d;

  counter_seq_predict #(
    .WIDTH (WIDTH)
  ) u_predict (
    .prev_i    (prev_q),
    .prev_tc_i (prev_tc_q),
    .step_i    (step_i),
    .dir_i     (dir_i),
    .exp_o     (exp_cnt),
    .exp_tc_o  (exp_tc),
    .wrap_o    (wrap)
  );

  assign cnt_match = (count_i == exp_cnt);
  assign tc_match  = (tc_i == exp_tc);
  assign good_d    = good_q + CNT_W'(1);

`ifdef COUNTER_MON_HOLD_CHECK_EN
  assign chk_en = 1'b1;
`else
  assign chk_en = step_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNSYNC;
      prev_q       <= '0;
      prev_tc_q    <= 1'b0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      tc_err_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_q       <= '0;
    end else begin
      seq_err_q <= 1'b0;
      tc_err_q  <= 1'b0;
      prev_tc_q <= tc_i;
      // The last good reference is kept while faulted.
      if (state_q != FAULT) prev_q <= count_i;
      // A new error later in this block overrides the clear.
      if (clr_err_i) err_sticky_q <= 1'b0;

      case (state_q)
        UNSYNC: begin
          good_q  <= '0;
          state_q <= SYNC;
        end
        SYNC: begin
          if (step_i) begin
            if (cnt_match && tc_match) begin
              good_q <= good_d;
              if (good_d == SYNC_LEN_C) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (chk_en && !(cnt_match && tc_match)) begin
            seq_err_q    <= !cnt_match;
            tc_err_q     <= !tc_match;
            err_sticky_q <= 1'b1;
            locked_q     <= 1'b0;
            state_q      <= FAULT;
          end else if (step_i && wrap && !(&wrap_q)) begin
            wrap_q <= wrap_q + WRAP_W'(1);
          end
        end
        FAULT: begin
          if (clr_err_i) state_q <= UNSYNC;
        end
        default: state_q <= UNSYNC;
      endcase
    end
  end

  assign locked_o     = locked_q;
  assign seq_err_o    = seq_err_q;
  assign tc_err_o     = tc_err_q;
  assign err_sticky_o = err_sticky_q;
  assign wrap_cnt_o   = wrap_q;

endmodule
`default_nettype wire
